// File: rtl/regfile_pkg.sv
// Shared defaults and types for the integer register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned AW_DEF   = 5;

    typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage : regfile_pkg

// File: rtl/regfile.sv
// Two-read / one-write register file with a hardwired-zero x0 and synchronous clear.
// Reads are combinational and see the pre-edge contents (no write-to-read bypass).
module regfile
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = AW_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            rd_wren,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data
);

    // x0 has no storage; the array starts at x1.
    logic [XLEN-1:0] regs [1:NREG-1];

    // Reset clears everything and overrides any write in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            regs <= '{default: '0};
        end else if (rd_wren && (rd_addr != '0)) begin
            regs[rd_addr] <= rd_data;
        end
    end

    always_comb begin
        rs1_data = '0;
        if (rs1_addr != '0) begin
            rs1_data = regs[rs1_addr];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != '0) begin
            rs2_data = regs[rs2_addr];
        end
    end

endmodule : regfile

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus queues expected reads, a monitor compares them.
module tb_regfile;
    import regfile_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        rd_wren;
    reg_addr_t   rd_addr;
    logic [31:0] rd_data;
    reg_addr_t   rs1_addr;
    reg_addr_t   rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    typedef struct {
        string       name;
        bit          port;
        logic [4:0]  addr;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    event sample_ev;
    int   tests  = 0;
    int   failed = 0;

    regfile #(.XLEN(32), .NREG(32), .AW(5)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .rd_wren  (rd_wren),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: whenever the stimulus flags a read as presented, drain and compare.
    initial begin
        chk_t        e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (q.size() > 0) begin
                e   = q.pop_front();
                act = e.port ? rs2_data : rs1_data;
                tests++;
                if (act !== e.exp) begin
                    failed++;
                    $display("FAIL %s rs%0d addr=%0d got=%h want=%h",
                             e.name, e.port ? 2 : 1, e.addr, act, e.exp);
                end
            end
        end
    end

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h0101_0101) ^ 32'h8000_0003;
    endfunction

    // Present an address on one read port and queue its expected data.
    task automatic chk(input bit port, input logic [4:0] a, input logic [31:0] exp,
                       input string name);
        chk_t e;
        if (port) rs2_addr = a;
        else      rs1_addr = a;
        #1;
        e.name = name; e.port = port; e.addr = a; e.exp = exp;
        q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    // Apply write controls for exactly one rising edge, return at the next falling edge.
    task automatic wr(input logic en, input logic [4:0] a, input logic [31:0] d);
        rd_wren = en; rd_addr = a; rd_data = d;
        @(posedge clk_i);
        @(negedge clk_i);
        rd_wren = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b1; rd_wren = 1'b0; rd_addr = '0; rd_data = '0;
        rs1_addr = '0; rs2_addr = '0;

        // One reset edge, then every address reads zero on both ports.
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk(1'b0, 5'(i), 32'h0, "reset_rs1");
            chk(1'b1, 5'(i), 32'h0, "reset_rs2");
        end

        @(negedge clk_i);
        wr(1'b1, 5'd1, 32'hAAAA_AAAA);
        wr(1'b1, 5'd2, 32'h5555_5555);
        wr(1'b1, 5'd3, 32'h1234_5678);
        wr(1'b1, 5'd6, 32'h1200_1235);
        chk(1'b0, 5'd1, 32'hAAAA_AAAA, "write_x1");
        chk(1'b1, 5'd2, 32'h5555_5555, "write_x2");
        chk(1'b0, 5'd3, 32'h1234_5678, "write_x3");
        chk(1'b0, 5'd6, 32'h1200_1235, "write_x6");
        chk(1'b1, 5'd6, 32'h1200_1235, "write_x6_rs2");
        chk(1'b0, 5'd4, 32'h0,         "unwritten_x4");

        @(negedge clk_i);
        wr(1'b1, 5'd0, 32'hDEAD_BEEF);
        chk(1'b0, 5'd0, 32'h0, "x0_rs1");
        chk(1'b1, 5'd0, 32'h0, "x0_rs2");

        @(negedge clk_i);
        wr(1'b0, 5'd3, 32'hFFFF_FFFF);
        chk(1'b0, 5'd3, 32'h1234_5678, "wren_low_x3");

        // Same-cycle read/write: old value before the edge, new value after.
        @(negedge clk_i);
        rs1_addr = 5'd5;
        rd_wren = 1'b1; rd_addr = 5'd5; rd_data = 32'hCAFE_0001;
        chk(1'b0, 5'd5, 32'h0, "rw_same_before");
        @(posedge clk_i);
        @(negedge clk_i);
        rd_wren = 1'b0;
        chk(1'b0, 5'd5, 32'hCAFE_0001, "rw_same_after");

        // Distinct pattern in every register, read back on both ports in opposite orders.
        @(negedge clk_i);
        for (int i = 1; i < 32; i++) wr(1'b1, 5'(i), pat(i));
        wr(1'b1, 5'd0, 32'hDEAD_BEEF);
        for (int i = 0; i < 32; i++) begin
            chk(1'b0, 5'(i),      (i == 0) ? 32'h0 : pat(i),      "fill_rs1");
            chk(1'b1, 5'(31 - i), (i == 31) ? 32'h0 : pat(31 - i), "fill_rs2");
        end
        rs1_addr = 5'd17; rs2_addr = 5'd17;
        chk(1'b0, 5'd17, pat(17), "same_addr_rs1");
        chk(1'b1, 5'd17, pat(17), "same_addr_rs2");

        // Reset with a concurrent write: write lost, all earlier values cleared.
        @(negedge clk_i);
        rst_ni = 1'b1;
        wr(1'b1, 5'd7, 32'h0000_00FF);
        rst_ni = 1'b0;
        chk(1'b0, 5'd7, 32'h0, "rst_prio_x7");
        chk(1'b1, 5'd1, 32'h0, "rst_prio_x1");
        for (int i = 0; i < 32; i++) chk(1'b0, 5'(i), 32'h0, "midop_reset");

        #5;
        if (q.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL scoreboard_drain left=%0d want=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Hard bound in case stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout got=stalled want=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_regfile

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data width of each register and of each data port.
REQ-002 The block SHALL have parameter NREG, default 32, meaning number of architectural registers (x0..x31).
REQ-003 The block SHALL have parameter AW, default 5, meaning address width, with the constraint 2**AW == NREG.
REQ-004 The block SHALL have one clock and a reset that is synchronous and active-high: clk_i input 1 is the clock (all state updates on its rising edge), and rst_ni input 1 is the reset, synchronous and active-high.
REQ-005 The block SHALL have port rd_wren, input, 1 bit, meaning write enable for the destination register.
REQ-006 The block SHALL have port rd_addr, input, AW bits, meaning destination register address.
REQ-007 The block SHALL have port rd_data, input, XLEN bits, meaning write data.
REQ-008 The block SHALL have port rs1_addr, input, AW bits, meaning read port 1 address.
REQ-009 The block SHALL have port rs2_addr, input, AW bits, meaning read port 2 address.
REQ-010 The block SHALL have port rs1_data, output, XLEN bits, meaning read port 1 data.
REQ-011 The block SHALL have port rs2_data, output, XLEN bits, meaning read port 2 data.

Function
REQ-012 The block SHALL hold registers x1..x(NREG-1) as XLEN-bit state; x0 SHALL NOT be implemented as storage.
REQ-013 Reads SHALL be combinational (zero latency): rsN_data = x[rsN_addr], and it SHALL update in the same cycle the address changes.
REQ-014 A read of address 0 on either port SHALL return 0 regardless of any prior write.
REQ-015 At a rising clk_i edge with rst_ni low, rd_wren high and rd_addr != 0, the block SHALL store rd_data into x[rd_addr].
REQ-016 At a rising clk_i edge with rd_addr == 0, the write SHALL be discarded with no side effect.
REQ-017 At a rising clk_i edge with rd_wren low, no register SHALL change.
REQ-018 Read and write to the same address in one cycle: the read SHALL return the pre-edge (old) value, the new value SHALL be visible from the cycle after the edge, and there SHALL be no write-to-read bypass.
REQ-019 Both read ports SHALL be fully independent; the same address on both ports SHALL return identical data.
REQ-020 Unwritten registers SHALL read 0 after reset.

Reset
REQ-021 At a rising clk_i edge with rst_ni high, every register x1..x(NREG-1) SHALL be cleared to 0.
REQ-022 Reset SHALL have priority over a simultaneous write; the write is lost.
REQ-023 While rst_ni is high, the outputs SHALL follow the combinational read of the (zeroed) array; from the first edge after reset they SHALL read 0 for every address.
REQ-024 Reset asserted mid-operation SHALL clear all previously written values at the next edge.

Structure
REQ-025 Package regfile_pkg SHALL hold XLEN, NREG and AW defaults and a reg_addr_t typedef (AW bits).
REQ-026 The block SHALL be flat (array plus two read multiplexers); no sub-module is required.

Verification
REQ-027 Reset: assert rst_ni for 1 edge, then read all 32 addresses -> every value reads 0x0000_0000.
REQ-028 Writes: with rd_wren=1 on consecutive edges, write x1=AAAA_AAAA, x2=5555_5555, x3=1234_5678, x6=1200_1235, then rd_wren=0 -> rs1(1)=AAAA_AAAA, rs2(2)=5555_5555, rs1(3)=1234_5678, rs1(6)=1200_1235.
REQ-029 x0: write DEAD_BEEF to address 0 -> rs1_data and rs2_data both read 0 at address 0.
REQ-030 Write disabled: rd_wren=0, rd_addr=3, rd_data=FFFF_FFFF for one edge -> x3 still reads 1234_5678.
REQ-031 Same-cycle read/write: rs1_addr=5 while writing x5=CAFE_0001 -> 0 before the edge and CAFE_0001 after it.
REQ-032 Reset priority: rst_ni=1 with rd_wren=1, rd_addr=7, rd_data=0000_00FF -> x7 reads 0 and x1 reads 0.
